hit_event_scheduler: RTL and testbench

HIT_EVENT_SCHEDULER -- requirements
Module: hit_event_scheduler

---
 rtl/hit_sched_pkg.sv | 21 ++
 rtl/hit_cooldown_counter.sv | 29 ++
 rtl/hit_event_scheduler.sv | 125 ++++++++++++
 tb/tb_hit_event_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hit_sched_pkg.sv
// Shared types and constants for the hit event scheduler: FSM states,
// source indices and field widths.
package hit_sched_pkg;

   localparam int EVENT_ID_W = 3;
   localparam int CD_W       = 4;
   localparam int TMO_W      = 2;

   localparam int SRC_OBST1   = 0;
   localparam int SRC_OBST2   = 1;
   localparam int SRC_OBST3   = 2;
   localparam int SRC_SPECIAL = 3;
   localparam int SRC_BUMPER  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARB   = 2'd1,
      ISSUE = 2'd2
   } sched_state_e;

endpackage

// File: rtl/hit_cooldown_counter.sv
// Per-source cooldown: loaded on grant, counts frames down to zero.
// A load beats a same-cycle frame decrement.
module hit_cooldown_counter
   import hit_sched_pkg::*;
#(
   parameter int COOLDOWN_FRAMES = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic frame,
   input  logic load,
   output logic zero
);

   logic [CD_W-1:0] count;

   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= CD_W'(COOLDOWN_FRAMES);
      end else if (frame && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/hit_event_scheduler.sv
// Latches per-source hit pulses and issues at most one event per frame,
// round-robin, with per-source cooldown and an ack timeout.
module hit_event_scheduler
   import hit_sched_pkg::*;
#(
   parameter int NUM_SRC            = 5,
   parameter int COOLDOWN_FRAMES    = 8,
   parameter int ACK_TIMEOUT_FRAMES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  startOfFrame,
   input  logic [NUM_SRC-1:0]    hit_req,
   input  logic                  event_ack,
   output logic                  event_valid,
   output logic [EVENT_ID_W-1:0] event_id,
   output logic                  event_dropped,
   output logic [NUM_SRC-1:0]    pending_mask,
   output logic                  busy,
   output sched_state_e          fsm_state
);

   // Handshake: event_valid/event_id hold steady from the ARB->ISSUE edge
   // until the cycle event_ack=1 (accepted) or the timeout fires (dropped).
   sched_state_e          state;
   logic [NUM_SRC-1:0]    cd_zero;
   logic [NUM_SRC-1:0]    cd_load;
   logic [NUM_SRC-1:0]    grant_onehot;
   logic [NUM_SRC-1:0]    pending_next;
   logic [EVENT_ID_W-1:0] winner;
   logic [EVENT_ID_W-1:0] last_grant;
   logic [TMO_W-1:0]      tmo_cnt;

   assign fsm_state = state;

   // Later k overwritten by earlier k, so the source right after last_grant wins.
   always_comb begin
      winner       = '0;
      grant_onehot = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         for (int i = 0; i < NUM_SRC; i++) begin
            if (pending_mask[i] && (i == (int'(last_grant) + 1 + k) % NUM_SRC)) begin
               winner          = EVENT_ID_W'(i);
               grant_onehot    = '0;
               grant_onehot[i] = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pending_next = pending_mask | (hit_req & cd_zero);
      if (state == ARB) begin
         pending_next = pending_next & ~grant_onehot;
      end
   end

   assign cd_load = (state == ARB) ? grant_onehot : '0;

   for (genvar g = 0; g < NUM_SRC; g++) begin : g_cd
      hit_cooldown_counter #(
         .COOLDOWN_FRAMES(COOLDOWN_FRAMES)
      ) u_cd (
         .clk   (clk),
         .reset (reset),
         .frame (startOfFrame),
         .load  (cd_load[g]),
         .zero  (cd_zero[g])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending_mask  <= '0;
         event_valid   <= 1'b0;
         event_dropped <= 1'b0;
         busy          <= 1'b0;
         event_id      <= '0;
         last_grant    <= EVENT_ID_W'(NUM_SRC - 1);
         tmo_cnt       <= '0;
      end else begin
         pending_mask  <= pending_next;
         event_dropped <= 1'b0;
         case (state)
            IDLE: begin
               if (startOfFrame && (pending_mask != '0)) begin
                  state <= ARB;
                  busy  <= 1'b1;
               end
            end
            ARB: begin
               event_id    <= winner;
               last_grant  <= winner;
               tmo_cnt     <= '0;
               event_valid <= 1'b1;
               state       <= ISSUE;
            end
            ISSUE: begin
               if (event_ack) begin
                  event_valid <= 1'b0;
                  busy        <= 1'b0;
                  state       <= IDLE;
               end else if (startOfFrame) begin
                  if ((tmo_cnt + 2'd1) == TMO_W'(ACK_TIMEOUT_FRAMES)) begin
                     event_valid   <= 1'b0;
                     event_dropped <= 1'b1;
                     busy          <= 1'b0;
                     tmo_cnt       <= '0;
                     state         <= IDLE;
                  end else begin
                     tmo_cnt <= tmo_cnt + 2'd1;
                  end
               end
            end
            default: begin
               state       <= IDLE;
               event_valid <= 1'b0;
               busy        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hit_event_scheduler.sv
// Bench for hit_event_scheduler: frame-level reference model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_hit_event_scheduler;
   import hit_sched_pkg::*;

   localparam int NUM = 5;
   localparam int CD  = 8;
   localparam int TMO = 2;

   logic                  clk = 1'b0;
   logic                  reset;
   logic                  startOfFrame;
   logic [NUM-1:0]        hit_req;
   logic                  event_ack;
   logic                  event_valid;
   logic [EVENT_ID_W-1:0] event_id;
   logic                  event_dropped;
   logic [NUM-1:0]        pending_mask;
   logic                  busy;
   sched_state_e          fsm_state;

   int n_checks = 0;
   int n_errors = 0;

   hit_event_scheduler #(
      .NUM_SRC(NUM), .COOLDOWN_FRAMES(CD), .ACK_TIMEOUT_FRAMES(TMO)
   ) dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .hit_req(hit_req),
      .event_ack(event_ack), .event_valid(event_valid), .event_id(event_id),
      .event_dropped(event_dropped), .pending_mask(pending_mask), .busy(busy),
      .fsm_state(fsm_state)
   );

   // clock / watchdog
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog expired");
   end

   function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // Reference model: pending set, cooldown in frames, one grant per frame.
   logic [NUM-1:0] m_pend;
   int             m_cd [NUM];
   int             old_cd [NUM];
   logic [NUM-1:0] old_pend;
   int             m_last, m_id, m_wait, m_grant, m_c;
   bit             m_arb, m_valid, m_drop;

   always @(posedge clk) begin
      if (reset) begin
         m_pend = '0;
         foreach (m_cd[i]) m_cd[i] = 0;
         m_last = NUM - 1; m_id = 0; m_wait = 0;
         m_arb = 0; m_valid = 0; m_drop = 0;
      end else begin
         old_pend = m_pend;
         old_cd   = m_cd;
         m_grant  = -1;
         m_drop   = 0;
         if (m_arb) begin
            for (int k = 1; k <= NUM; k++) begin
               m_c = (m_last + k) % NUM;
               if (m_grant < 0 && old_pend[m_c]) m_grant = m_c;
            end
         end
         for (int i = 0; i < NUM; i++) begin
            if (hit_req[i] && old_cd[i] == 0) m_pend[i] = 1'b1;
            if (i == m_grant) begin
               m_pend[i] = 1'b0;
               m_cd[i]   = CD;
            end else if (startOfFrame && m_cd[i] > 0) begin
               m_cd[i] = m_cd[i] - 1;
            end
         end
         if (m_arb) begin
            m_arb = 0; m_valid = 1; m_id = m_grant; m_last = m_grant; m_wait = 0;
         end else if (m_valid) begin
            if (event_ack) begin
               m_valid = 0;
            end else if (startOfFrame) begin
               m_wait++;
               if (m_wait == TMO) begin
                  m_valid = 0;
                  m_drop  = 1;
               end
            end
         end else if (startOfFrame && old_pend != '0) begin
            m_arb = 1;
         end
      end
   end

   // Compare process: DUT vs model on every cycle, sampled on the falling edge.
   always @(negedge clk) begin
      check("valid", event_valid, m_valid);
      check("busy", busy, m_arb | m_valid);
      check("dropped", event_dropped, m_drop);
      check("pending", pending_mask, m_pend);
      check("id", event_id, m_id);
      check("state", fsm_state, m_arb ? ARB : (m_valid ? ISSUE : IDLE));
   end

   // Driver: apply inputs for one cycle, return at the next falling edge.
   task automatic cyc(input bit rst, input bit sof, input logic [NUM-1:0] hit, input bit ack);
      reset = rst; startOfFrame = sof; hit_req = hit; event_ack = ack;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      cyc(1, 0, '0, 0);
      cyc(1, 0, '0, 0);
   endtask

   int exp_rr [3] = '{0, 2, 4};
   int period, fcnt;
   bit r_s, r_a, r_r;
   logic [NUM-1:0] r_h;

   initial begin
      reset = 1'b1; startOfFrame = 1'b0; hit_req = '0; event_ack = 1'b0;
      @(negedge clk);
      do_reset();
      check("rst_valid", event_valid, 0);
      check("rst_pending", pending_mask, 0);
      check("rst_busy", busy, 0);
      check("rst_id", event_id, 0);

      // basic grant
      cyc(0, 0, 5'b00010, 0);
      check("basic_pend", pending_mask, 5'b00010);
      cyc(0, 1, '0, 0);
      check("basic_arb_valid", event_valid, 0);
      check("basic_arb_busy", busy, 1);
      cyc(0, 0, '0, 0);
      check("basic_valid", event_valid, 1);
      check("basic_id", event_id, 1);
      check("basic_pend_clr", pending_mask, 0);
      check("model_id", m_id, 1);
      cyc(0, 0, '0, 0);
      cyc(0, 0, '0, 1);
      check("basic_ack_valid", event_valid, 0);
      check("basic_ack_busy", busy, 0);

      // round robin
      do_reset();
      cyc(0, 0, 5'b10101, 0);
      for (int f = 0; f < 3; f++) begin
         cyc(0, 1, '0, 0);
         cyc(0, 0, '0, 0);
         check("rr_id", event_id, exp_rr[f]);
         check("rr_valid", event_valid, 1);
         cyc(0, 0, '0, 1);
         cyc(0, 0, '0, 0);
      end
      check("rr_pend", pending_mask, 0);

      // cooldown on source 2
      do_reset();
      cyc(0, 0, 5'b00100, 0);
      cyc(0, 1, '0, 0);
      cyc(0, 0, '0, 0);
      check("cd_id", event_id, 2);
      cyc(0, 0, '0, 1);
      for (int k = 1; k <= 8; k++) begin
         cyc(0, 1, '0, 0);
         cyc(0, 0, 5'b00100, 0);
         check("cd_pending", pending_mask[2], (k == 8));
      end

      // timeout, with a second source still pending
      do_reset();
      cyc(0, 0, 5'b00011, 0);
      cyc(0, 1, '0, 0);
      cyc(0, 0, '0, 0);
      check("tmo_id", event_id, 0);
      check("tmo_pend", pending_mask, 5'b00010);
      cyc(0, 0, '0, 0);
      cyc(0, 1, '0, 0);
      check("tmo_sof1_valid", event_valid, 1);
      check("tmo_sof1_drop", event_dropped, 0);
      check("tmo_no_rearb", fsm_state, ISSUE);
      cyc(0, 0, '0, 0);
      cyc(0, 1, '0, 0);
      check("tmo_drop", event_dropped, 1);
      check("tmo_drop_valid", event_valid, 0);
      cyc(0, 0, '0, 0);
      check("tmo_drop_pulse", event_dropped, 0);

      // ack on the timeout cycle wins
      do_reset();
      cyc(0, 0, 5'b00001, 0);
      cyc(0, 1, '0, 0);
      cyc(0, 0, '0, 0);
      cyc(0, 1, '0, 0);
      cyc(0, 1, '0, 1);
      check("ackwin_drop", event_dropped, 0);
      check("ackwin_valid", event_valid, 0);

      // reset in the middle of ISSUE
      do_reset();
      cyc(0, 0, 5'b00011, 0);
      cyc(0, 1, '0, 0);
      cyc(0, 0, '0, 0);
      check("rmid_valid_before", event_valid, 1);
      cyc(1, 1, 5'b11111, 1);
      check("rmid_valid", event_valid, 0);
      check("rmid_pend", pending_mask, 0);
      check("rmid_drop", event_dropped, 0);
      cyc(0, 0, 5'b01000, 0);
      check("rmid_new_hit", pending_mask, 5'b01000);

      // randomized traffic against the model
      period = 6; fcnt = 0;
      for (int n = 0; n < 2500; n++) begin
         r_s = 0;
         fcnt++;
         if (fcnt >= period) begin
            r_s = 1; fcnt = 0; period = $urandom_range(3, 9);
         end
         for (int i = 0; i < NUM; i++) r_h[i] = ($urandom_range(0, 9) == 0);
         r_a = ($urandom_range(0, 5) == 0);
         r_r = ($urandom_range(0, 299) == 0);
         cyc(r_r, r_s, r_h, r_a);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
